// File: rtl/audio_player.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | audio_player: byte FIFO, sample-rate pacer and 8-bit PWM audio output    |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module audio_player #(
  parameter int DEPTH       = 256,
  parameter int SAMPLE_DIV  = 6250,
  parameter int START_LEVEL = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     axiiv,
  input  logic [7:0]               axiid,
  output logic                     pwm_out,
  output logic [7:0]               sample_out,
  output logic [$clog2(DEPTH):0]   fill_count,
  output logic                     playing,
  output logic                     underflow,
  output logic                     overflow
);
  localparam int c_AW = $clog2(DEPTH);
  localparam int c_DW = $clog2(SAMPLE_DIV);
  localparam logic [c_AW:0]   c_DEPTH   = (c_AW+1)'(DEPTH);
  localparam logic [c_AW:0]   c_START   = (c_AW+1)'(START_LEVEL);
  localparam logic [c_DW-1:0] c_DIV_MAX = c_DW'(SAMPLE_DIV - 1);
  localparam logic [7:0]      c_SILENCE = 8'd128;

  localparam logic [0:0] c_ST_BUFFER = 1'b0;
  localparam logic [0:0] c_ST_PLAY   = 1'b1;

  logic [7:0]      r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW:0]   r_fill;
  logic [c_DW-1:0] r_div;
  logic [0:0]      r_state;
  logic [0:0]      w_state_next;
  logic            r_playing;
  logic            r_underflow;
  logic            r_overflow;
  logic            r_pwm;
  logic [7:0]      r_sample;
  logic [7:0]      r_pwm_cnt;
  logic            w_tick;
  logic            w_pop;
  logic            w_starve;
  logic            w_push;

  assign w_tick   = (r_div == c_DIV_MAX);
  assign w_pop    = (r_state == c_ST_PLAY) && w_tick && (r_fill != '0);
  assign w_starve = (r_state == c_ST_PLAY) && w_tick && (r_fill == '0);
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign w_push   = !rst && axiiv && ((r_fill != c_DEPTH) || w_pop);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_BUFFER: if (r_fill >= c_START) w_state_next = c_ST_PLAY;
      c_ST_PLAY:   if (w_starve)          w_state_next = c_ST_BUFFER;
      default:                            w_state_next = c_ST_BUFFER;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= axiid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fill      <= '0;
      r_div       <= '0;
      r_pwm_cnt   <= 8'd0;
      r_pwm       <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_sample    <= c_SILENCE;
      r_state     <= c_ST_BUFFER;
      r_playing   <= 1'b0;
    end else begin
      r_div     <= w_tick ? '0 : r_div + 1'b1;
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
      r_pwm     <= (r_pwm_cnt < r_sample);

      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase

      if (axiiv && !w_push) r_overflow <= 1'b1;
      r_underflow <= w_starve;

      if (w_pop)         r_sample <= r_mem[r_rd_ptr];
      else if (w_starve) r_sample <= c_SILENCE;

      r_state   <= w_state_next;
      r_playing <= (w_state_next == c_ST_PLAY);
    end
  end

  assign pwm_out    = r_pwm;
  assign sample_out = r_sample;
  assign fill_count = r_fill;
  assign playing    = r_playing;
  assign underflow  = r_underflow;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_audio_player.sv
`default_nettype none
// Directed bench for audio_player: FIFO, pacing, under/overflow and PWM duty.
module tb_audio_player;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // a: START_LEVEL=4, b: START_LEVEL=8, c: slow sample rate for PWM duty.
  logic       iv_a = 1'b0, iv_b = 1'b0, iv_c = 1'b0;
  logic [7:0] id_a = 8'd0, id_b = 8'd0, id_c = 8'd0;
  logic       pwm_a, pwm_b, pwm_c;
  logic [7:0] smp_a, smp_b, smp_c;
  logic [3:0] fill_a, fill_b, fill_c;
  logic       play_a, play_b, play_c;
  logic       und_a, und_b, und_c;
  logic       ovf_a, ovf_b, ovf_c;

  audio_player #(.DEPTH(8), .SAMPLE_DIV(16), .START_LEVEL(4)) dut_a (
    .clk(clk), .rst(rst), .axiiv(iv_a), .axiid(id_a), .pwm_out(pwm_a),
    .sample_out(smp_a), .fill_count(fill_a), .playing(play_a),
    .underflow(und_a), .overflow(ovf_a));

  audio_player #(.DEPTH(8), .SAMPLE_DIV(16), .START_LEVEL(8)) dut_b (
    .clk(clk), .rst(rst), .axiiv(iv_b), .axiid(id_b), .pwm_out(pwm_b),
    .sample_out(smp_b), .fill_count(fill_b), .playing(play_b),
    .underflow(und_b), .overflow(ovf_b));

  audio_player #(.DEPTH(8), .SAMPLE_DIV(2048), .START_LEVEL(1)) dut_c (
    .clk(clk), .rst(rst), .axiiv(iv_c), .axiid(id_c), .pwm_out(pwm_c),
    .sample_out(smp_c), .fill_count(fill_c), .playing(play_c),
    .underflow(und_c), .overflow(ovf_c));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic to_cyc(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1; iv_a = 1'b0; iv_b = 1'b0; iv_c = 1'b0;
    step(); step();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic pwm_count(input string tag, input int exp);
    int hi;
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      hi += int'(pwm_c);
    end
    check(tag, hi, exp);
  endtask

  initial begin
    // ---------------- reset state and buffering ----------------
    do_reset();
    check("rst_playing", play_a, 1'b0);
    check("rst_sample", smp_a, 8'h80);
    check("rst_fill", fill_a, 4'd0);
    check("rst_underflow", und_a, 1'b0);
    check("rst_overflow", ovf_a, 1'b0);
    check("rst_pwm", pwm_a, 1'b0);

    iv_a = 1'b1;
    id_a = 8'h10; step();
    id_a = 8'h20; step();
    id_a = 8'h30; step();
    iv_a = 1'b0;
    to_cyc(103);
    check("buf_playing", play_a, 1'b0);
    check("buf_sample", smp_a, 8'h80);
    check("buf_fill", fill_a, 4'd3);

    iv_a = 1'b1; id_a = 8'h40; step(); iv_a = 1'b0;
    check("fill4", fill_a, 4'd4);
    check("play_not_yet", play_a, 1'b0);
    step();
    check("play_start", play_a, 1'b1);
    to_cyc(111);
    check("pre_tick_sample", smp_a, 8'h80);
    check("pre_tick_fill", fill_a, 4'd4);
    step();
    check("pop1_sample", smp_a, 8'h10);
    check("pop1_fill", fill_a, 4'd3);
    to_cyc(128);
    check("pop2_sample", smp_a, 8'h20);
    check("pop2_fill", fill_a, 4'd2);
    to_cyc(144);
    check("pop3_sample", smp_a, 8'h30);
    check("pop3_fill", fill_a, 4'd1);
    to_cyc(160);
    check("pop4_sample", smp_a, 8'h40);
    check("pop4_fill", fill_a, 4'd0);

    // underflow tick with a simultaneous push
    to_cyc(175);
    iv_a = 1'b1; id_a = 8'h55; step(); iv_a = 1'b0;
    check("uf_pulse", und_a, 1'b1);
    check("uf_sample", smp_a, 8'h80);
    check("uf_playing", play_a, 1'b0);
    check("uf_fill", fill_a, 4'd1);
    step();
    check("uf_one_cycle", und_a, 1'b0);

    // reset in the middle of playback, with a strobe during reset
    iv_a = 1'b1;
    id_a = 8'h61; step();
    id_a = 8'h62; step();
    id_a = 8'h63; step();
    iv_a = 1'b0;
    to_cyc(192);
    check("replay_sample", smp_a, 8'h55);
    check("replay_playing", play_a, 1'b1);
    rst = 1'b1; iv_a = 1'b1; id_a = 8'h77;
    step();
    check("midrst_fill", fill_a, 4'd0);
    check("midrst_sample", smp_a, 8'h80);
    check("midrst_playing", play_a, 1'b0);
    check("midrst_underflow", und_a, 1'b0);
    check("midrst_overflow", ovf_a, 1'b0);
    check("midrst_pwm", pwm_a, 1'b0);
    rst = 1'b0; iv_a = 1'b0;
    step();
    check("midrst_strobe_ignored", fill_a, 4'd0);

    // ---------------- overflow: 10 bytes into a depth-8 FIFO ----------------
    do_reset();
    check("ovf_rst", ovf_b, 1'b0);
    iv_b = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      id_b = 8'hB0 + 8'(k);
      step();
    end
    iv_b = 1'b0;
    check("ovf_fill", fill_b, 4'd8);
    check("ovf_flag", ovf_b, 1'b1);
    check("ovf_playing", play_b, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      to_cyc(16 * k);
      check($sformatf("ovf_pop%0d", k), smp_b, 8'hB0 + 8'(k));
    end
    to_cyc(144);
    check("ovf_drained_uf", und_b, 1'b1);
    check("ovf_drained_sample", smp_b, 8'h80);
    check("ovf_sticky", ovf_b, 1'b1);

    // ---------------- full FIFO, push on a popping tick ----------------
    do_reset();
    iv_b = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      id_b = 8'hC0 + 8'(k);
      step();
    end
    iv_b = 1'b0;
    to_cyc(15);
    iv_b = 1'b1; id_b = 8'hAA; step(); iv_b = 1'b0;
    check("fulltick_fill", fill_b, 4'd8);
    check("fulltick_overflow", ovf_b, 1'b0);
    check("fulltick_sample", smp_b, 8'hC1);
    to_cyc(144);
    check("fulltick_byte_played", smp_b, 8'hAA);
    check("fulltick_fill_end", fill_b, 4'd0);

    // ---------------- PWM duty ----------------
    do_reset();
    iv_c = 1'b1;
    id_c = 8'h40; step();
    id_c = 8'h00; step();
    id_c = 8'hFF; step();
    iv_c = 1'b0;
    to_cyc(10);
    pwm_count("pwm_0x80", 128);
    to_cyc(2048 + 8);
    check("pwm_sample_0x40", smp_c, 8'h40);
    pwm_count("pwm_0x40", 64);
    to_cyc(4096 + 8);
    check("pwm_sample_0x00", smp_c, 8'h00);
    pwm_count("pwm_0x00", 0);
    to_cyc(6144 + 8);
    check("pwm_sample_0xFF", smp_c, 8'hFF);
    pwm_count("pwm_0xFF", 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
